// File: rtl/jkff_bist_pkg.sv
// ---------------------------------------------------------------------------
// jkff_bist_pkg
// Shared definitions for the JK flip-flop self-test engine:
//   - state_t          : FSM state encoding
//   - STEP_J / STEP_K  : J and K drive for excitation steps 0..7 (bit n = step n)
//   - STEP_EXP         : expected q after each step, starting from q=0
//   - RST_CHK_STEP     : fail_step code reported for a failing reset check
//   - CYCLES_PER_PASS  : busy cycles per pass (DRST + DRST_CHK + 8 x APPLY/CHECK)
//   - jk_next()        : JK next-state rule used by the reference model
// ---------------------------------------------------------------------------
package jkff_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRST,
        S_DRST_CHK,
        S_APPLY,
        S_CHECK,
        S_FIN
    } state_t;

    // Step:              7654_3210
    localparam logic [7:0] STEP_J   = 8'b0100_1101;
    localparam logic [7:0] STEP_K   = 8'b1101_1100;
    localparam logic [7:0] STEP_EXP = 8'b0100_1011;

    localparam logic [3:0] RST_CHK_STEP    = 4'd8;
    localparam int         CYCLES_PER_PASS = 18;

    // 00 hold, 01 clear, 10 set, 11 toggle
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nq;
        case ({j, k})
            2'b00:   nq = q;
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            default: nq = ~q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jkff_bist_model.sv
// ---------------------------------------------------------------------------
// jkff_bist_model
// One-bit JK reference register that tracks what a healthy flip-flop should
// hold. It is cleared alongside the DUT reset pulse and advanced on the same
// edge at which the DUT captures the applied J/K pair.
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   i_load_zero in   force the expected value to 0 (DUT is being reset)
//   i_en        in   apply the JK rule with i_j/i_k at this edge
//   i_j, i_k    in   J/K values currently driven to the DUT
//   o_q         out  expected DUT q
// ---------------------------------------------------------------------------
module jkff_bist_model
    import jkff_bist_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_load_zero,
    input  logic i_en,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic r_q;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (i_load_zero) begin
            r_q <= 1'b0;
        end else if (i_en) begin
            r_q <= jk_next(r_q, i_j, i_k);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jkff_bist.sv
// ---------------------------------------------------------------------------
// jkff_bist
// On-chip stimulus-and-check engine for a single JK flip-flop. Each pass
// resets the DUT, checks the reset value, then applies the 8-step J/K table
// and checks q/qbar one cycle after each application. NUM_PASSES passes
// make up one run; mismatches are counted (saturating) and the first
// failure location is recorded.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle run request (sampled only in IDLE)
//   j_out, k_out      registered J/K drive to the DUT
//   dut_rst           registered synchronous reset drive to the DUT
//   q_in, qbar_in     DUT outputs
//   busy              high while the run is in progress
//   done              sticky end-of-run flag, cleared by the next start
//   pass              1 when done and no mismatch occurred
//   err_count         saturating count of mismatching check cycles
//   fail_step         first failing step (0-7, 8 = reset check)
//   fail_pass         pass index of the first failure
// Configuration macro:
//   JKFF_BIST_STOP_ON_FAIL_EN  end the run at the first mismatch
// ---------------------------------------------------------------------------
module jkff_bist
    import jkff_bist_pkg::*;
#(
    parameter int NUM_PASSES = 4,
    parameter int PASS_W     = 8,
    parameter int ERR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              j_out,
    output logic              k_out,
    output logic              dut_rst,
    input  logic              q_in,
    input  logic              qbar_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [3:0]        fail_step,
    output logic [PASS_W-1:0] fail_pass
);

    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_PASSES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};

    state_t            r_state;
    logic [2:0]        r_step;
    logic [PASS_W-1:0] r_pass_idx;

    logic              w_exp_q;
    logic              w_chk;
    logic              w_mismatch;
    logic              w_first_fail;
    logic              w_stop;
    logic              w_run_end;
    logic [2:0]        w_next_step;
    logic [3:0]        w_cur_step;
    logic [ERR_W-1:0]  w_err_next;

    jkff_bist_model u_model (
        .clk         (clk),
        .rst         (rst),
        .i_load_zero (r_state == S_DRST),
        .i_en        (r_state == S_APPLY),
        .i_j         (j_out),
        .i_k         (k_out),
        .o_q         (w_exp_q)
    );

    // DUT outputs are compared during the reset-check and check cycles; a
    // wrong q and a wrong qbar in the same cycle count as one mismatch.
    assign w_chk        = (r_state == S_DRST_CHK) || (r_state == S_CHECK);
    assign w_mismatch   = w_chk && ((q_in != w_exp_q) || (qbar_in != ~w_exp_q));
    assign w_err_next   = (w_mismatch && (err_count != ERR_MAX)) ? err_count + ERR_W'(1)
                                                                 : err_count;
    // err_count never returns to zero within a run, so zero means no earlier failure.
    assign w_first_fail = w_mismatch && (err_count == '0);
    assign w_cur_step   = (r_state == S_DRST_CHK) ? RST_CHK_STEP : {1'b0, r_step};
    assign w_next_step  = r_step + 3'd1;
    assign w_run_end    = (r_step == 3'd7) && (r_pass_idx == LAST_PASS);

`ifdef JKFF_BIST_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_step     <= '0;
            r_pass_idx <= '0;
            j_out      <= 1'b0;
            k_out      <= 1'b0;
            dut_rst    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_step  <= '0;
            fail_pass  <= '0;
        end else begin
            if (w_chk) begin
                err_count <= w_err_next;
                if (w_first_fail) begin
                    fail_step <= w_cur_step;
                    fail_pass <= r_pass_idx;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        err_count  <= '0;
                        fail_step  <= '0;
                        fail_pass  <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        r_pass_idx <= '0;
                        dut_rst    <= 1'b1;
                        j_out      <= 1'b0;
                        k_out      <= 1'b0;
                        r_state    <= S_DRST;
                    end
                end

                S_DRST: begin
                    dut_rst <= 1'b0;
                    r_state <= S_DRST_CHK;
                end

                S_DRST_CHK: begin
                    if (w_stop) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == '0);
                        r_state <= S_FIN;
                    end else begin
                        r_step  <= 3'd0;
                        j_out   <= STEP_J[0];
                        k_out   <= STEP_K[0];
                        r_state <= S_APPLY;
                    end
                end

                S_APPLY: begin
                    j_out   <= 1'b0;
                    k_out   <= 1'b0;
                    r_state <= S_CHECK;
                end

                S_CHECK: begin
                    if (w_stop || w_run_end) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == '0);
                        r_state <= S_FIN;
                    end else if (r_step != 3'd7) begin
                        r_step  <= w_next_step;
                        j_out   <= STEP_J[w_next_step];
                        k_out   <= STEP_K[w_next_step];
                        r_state <= S_APPLY;
                    end else begin
                        r_pass_idx <= r_pass_idx + PASS_W'(1);
                        dut_rst    <= 1'b1;
                        r_state    <= S_DRST;
                    end
                end

                S_FIN: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jkff_bist.sv
// ---------------------------------------------------------------------------
// tb_jkff_bist
// Bench for jkff_bist with a JK flip-flop attached that can be switched into
// several fault modes:
//   0 healthy, 1 q stuck at 0 (qbar = ~q), 2 JK=11 holds instead of toggling,
//   3 qbar stuck at 1.
// Expected run results are derived from the step table and pushed into a
// scoreboard queue at each start; they are popped when done rises.
// ---------------------------------------------------------------------------
module tb_jkff_bist;
    import jkff_bist_pkg::*;

    localparam int NUM_PASSES = 4;
    localparam int PASS_W     = 8;
    localparam int ERR_W      = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              j_out, k_out, dut_rst;
    logic              q_in, qbar_in;
    logic              busy, done, pass;
    logic [ERR_W-1:0]  err_count;
    logic [3:0]        fail_step;
    logic [PASS_W-1:0] fail_pass;

    int fault_mode = 0;
    int n_vec      = 0;
    int n_miss     = 0;

    typedef struct {
        int busy_cycles;
        int err;
        int fstep;
        int fpass;
        int pass;
    } exp_t;

    exp_t sb_q[$];

    // J/K drive for steps 0..7
    int tb_j[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int tb_k[8] = '{0, 0, 1, 1, 1, 0, 1, 1};

    always #5 clk = ~clk;

    jkff_bist #(
        .NUM_PASSES (NUM_PASSES),
        .PASS_W     (PASS_W),
        .ERR_W      (ERR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .j_out     (j_out),
        .k_out     (k_out),
        .dut_rst   (dut_rst),
        .q_in      (q_in),
        .qbar_in   (qbar_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_step (fail_step),
        .fail_pass (fail_pass)
    );

    // Flip-flop under test, with optional faults
    logic ff_q;
    logic ff_qv;

    always_ff @(posedge clk) begin
        if (dut_rst) begin
            ff_q <= 1'b0;
        end else begin
            case ({j_out, k_out})
                2'b00:   ff_q <= ff_q;
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                default: ff_q <= (fault_mode == 2) ? ff_q : ~ff_q;
            endcase
        end
    end

    assign ff_qv   = (fault_mode == 1) ? 1'b0 : ff_q;
    assign q_in    = ff_qv;
    assign qbar_in = (fault_mode == 3) ? 1'b1 : ~ff_qv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int jk(input int q, input int j, input int k);
        if (j == 0 && k == 0) return q;
        if (j == 0 && k == 1) return 0;
        if (j == 1 && k == 0) return 1;
        return (q == 0) ? 1 : 0;
    endfunction

    // Expected run outcome for a given fault mode. The reset check passes
    // for every fault mode modelled here (q=0, qbar=1 after reset).
    function automatic exp_t compute_exp(input int mode);
        exp_t r;
        int   fq, oq, oqb, e;
        bit   stopped;
        r.busy_cycles = 0;
        r.err         = 0;
        r.fstep       = 0;
        r.fpass       = 0;
        stopped       = 1'b0;
        for (int p = 0; p < NUM_PASSES && !stopped; p++) begin
            r.busy_cycles += 2;
            fq = 0;
            for (int s = 0; s < 8 && !stopped; s++) begin
                if (mode == 2 && tb_j[s] == 1 && tb_k[s] == 1) fq = fq;
                else fq = jk(fq, tb_j[s], tb_k[s]);
                oq  = (mode == 1) ? 0 : fq;
                oqb = (mode == 3) ? 1 : 1 - oq;
                e   = int'(STEP_EXP[s]);
                r.busy_cycles += 2;
                if (oq != e || oqb != 1 - e) begin
                    if (r.err == 0) begin
                        r.fstep = s;
                        r.fpass = p;
                    end
                    if (r.err < 255) r.err++;
`ifdef JKFF_BIST_STOP_ON_FAIL_EN
                    stopped = 1'b1;
`endif
                end
            end
        end
        r.pass = (r.err == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
        check({tag, "_pass"},      32'(pass),      32'd0);
        check({tag, "_err"},       32'(err_count), 32'd0);
        check({tag, "_fail_step"}, 32'(fail_step), 32'd0);
        check({tag, "_fail_pass"}, 32'(fail_pass), 32'd0);
        check({tag, "_drive"},     32'({dut_rst, j_out, k_out}), 32'd0);
    endtask

    task automatic run_one(input int mode, input bit chk_stim, input bit poke_start);
        exp_t e;
        int   cycles, guard, idx, st;
        logic [2:0] exp_drv;
        fault_mode = mode;
        sb_q.push_back(compute_exp(mode));
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cycles = 0;
        guard  = 0;
        while (!done && guard < 2000) begin
            if (busy) begin
                if (chk_stim) begin
                    idx = cycles % CYCLES_PER_PASS;
                    if (idx == 0)      exp_drv = 3'b100;
                    else if (idx == 1) exp_drv = 3'b000;
                    else begin
                        st = (idx - 2) / 2;
                        exp_drv = ((idx - 2) % 2 == 0) ? {1'b0, tb_j[st][0], tb_k[st][0]} : 3'b000;
                    end
                    check($sformatf("stim_c%0d", cycles), 32'({dut_rst, j_out, k_out}), 32'(exp_drv));
                end
                cycles++;
            end
            start = (poke_start && cycles == 10) ? 1'b1 : 1'b0;
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        check($sformatf("m%0d_done_timeout", mode), 32'(done), 32'd1);
        e = sb_q.pop_front();
        check($sformatf("m%0d_busy_cycles", mode), 32'(cycles),    32'(e.busy_cycles));
        check($sformatf("m%0d_busy_low", mode),    32'(busy),      32'd0);
        check($sformatf("m%0d_err_count", mode),   32'(err_count), 32'(e.err));
        check($sformatf("m%0d_fail_step", mode),   32'(fail_step), 32'(e.fstep));
        check($sformatf("m%0d_fail_pass", mode),   32'(fail_pass), 32'(e.fpass));
        check($sformatf("m%0d_pass", mode),        32'(pass),      32'(e.pass));
        // start during FIN must be ignored; done stays sticky afterwards
        if (poke_start) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
        check($sformatf("m%0d_done_sticky", mode), 32'(done), 32'd1);
        check($sformatf("m%0d_idle_busy", mode),   32'(busy), 32'd0);
        check($sformatf("m%0d_err_hold", mode),    32'(err_count), 32'(e.err));
    endtask

    initial begin
        int guard, cycles;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        run_one(0, 1'b1, 1'b0);
        run_one(1, 1'b0, 1'b0);
        run_one(2, 1'b0, 1'b0);
        run_one(3, 1'b0, 1'b0);

        // Abort a run in the middle of pass index 2
        fault_mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cycles = 0;
        guard  = 0;
        while (cycles < 40 && guard < 2000) begin
            if (busy) cycles++;
            @(negedge clk);
            guard++;
        end
        check("abort_reached", 32'(cycles), 32'd40);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("abort");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_done_low", 32'(done), 32'd0);
        check("abort_busy_low", 32'(busy), 32'd0);

        // Fresh run after abort, with start pulses while busy and in FIN
        run_one(0, 1'b0, 1'b1);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
